// File: rtl/amp_seq_pkg.sv
// Shared state encoding and default timing for the amplifier power sequencer.
package amp_seq_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    WAIT_Q  = 3'd1,
    STARTUP = 3'd2,
    RUN     = 3'd3,
    RETRY   = 3'd4,
    LOCK    = 3'd5
  } amp_state_t;

  localparam int DEF_NUM_AMP     = 2;
  localparam int DEF_STARTUP_CYC = 250000;   // 5 ms at 50 MHz
  localparam int DEF_RETRY_CYC   = 2500000;  // 50 ms at 50 MHz
  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_DEB_CYC     = 16;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flt_filt.sv
// Per-channel fault filter: 2-flop synchroniser of the active-low fault pin, active-high result.
// With AMP_FLT_DEBOUNCE_EN the output only follows after DEB_CYC stable clocks (both directions).
module flt_filt
`ifdef AMP_FLT_DEBOUNCE_EN
  #(parameter int DEB_CYC = 16)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic flt_n_async,
  output logic flt
);

  logic [1:0] sync;

  // Reset to the "no fault" level so a reset never reports a phantom fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], flt_n_async};
  end

`ifdef AMP_FLT_DEBOUNCE_EN
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_END = DW'(DEB_CYC - 1);

  logic [DW-1:0] cnt;
  logic          flt_q;
  logic          raw;

  assign raw = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      flt_q <= 1'b0;
    end else if (raw != flt_q) begin
      if (cnt == DEB_END) begin
        flt_q <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign flt = flt_q;
`else
  assign flt = ~sync[1];
`endif

endmodule

// File: rtl/amp_pwr_seq.sv
// Class-D amp power sequencer: shutdown until queues full, settle, unmute; timed retry then lockout on faults.
// Optional fault debounce in each channel filter when AMP_FLT_DEBOUNCE_EN is defined.
module amp_pwr_seq
  import amp_seq_pkg::*;
#(
  parameter int NUM_AMP     = DEF_NUM_AMP,
  parameter int STARTUP_CYC = DEF_STARTUP_CYC,
  parameter int RETRY_CYC   = DEF_RETRY_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
`ifdef AMP_FLT_DEBOUNCE_EN
  , parameter int DEB_CYC   = DEF_DEB_CYC
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               q_full,
  input  logic [NUM_AMP-1:0] Flt_n,
  input  logic               clr_flt,
  output logic [NUM_AMP-1:0] sht_dwn,
  output logic               mute,
  output logic [NUM_AMP-1:0] flt_sts,
  output logic               lockout,
  output logic [2:0]         state
);

  localparam int TW = cnt_w((STARTUP_CYC > RETRY_CYC) ? STARTUP_CYC : RETRY_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] ST_END    = TW'(STARTUP_CYC - 1);
  localparam logic [TW-1:0] RT_END    = TW'(RETRY_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  logic [NUM_AMP-1:0] flt;
  logic               flt_any;

  for (genvar i = 0; i < NUM_AMP; i++) begin : g_filt
    flt_filt
`ifdef AMP_FLT_DEBOUNCE_EN
      #(.DEB_CYC(DEB_CYC))
`endif
      u_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .flt_n_async(Flt_n[i]),
        .flt        (flt[i])
      );
  end

  assign flt_any = |flt;

  amp_state_t    state_q, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt, retry_inc;
  logic          tmr_restart;
  logic          pwr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OFF;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    retry_nxt   = retry_cnt;
    retry_inc   = retry_cnt + RW'(1);
    tmr_restart = 1'b0;
    unique case (state_q)
      OFF:    if (en) state_nxt = WAIT_Q;
      WAIT_Q: if (q_full) state_nxt = STARTUP;
      STARTUP, RUN: begin
        if (flt_any) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RETRY_LIM) ? LOCK : RETRY;
        end else if (state_q == STARTUP && timer == ST_END) begin
          state_nxt = RUN;
        end
      end
      RETRY: begin
        // A fault still present at expiry re-arms the wait without spending a retry.
        if (timer == RT_END) begin
          if (flt_any) tmr_restart = 1'b1;
          else         state_nxt   = WAIT_Q;
        end
      end
      LOCK: begin
        if (clr_flt) begin
          state_nxt = OFF;
          retry_nxt = '0;
        end
      end
      default: state_nxt = OFF;
    endcase

    // Dropping the enable overrides everything except a latched lockout.
    if (!en && state_q != LOCK) begin
      state_nxt = OFF;
      retry_nxt = '0;
    end

    if (state_nxt != state_q || tmr_restart)
      timer_nxt = '0;
    else if ((state_q == STARTUP || state_q == RETRY) && timer != '1)
      timer_nxt = timer + TW'(1);
    else
      timer_nxt = timer;

    pwr_nxt = (state_nxt == STARTUP) || (state_nxt == RUN);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      retry_cnt <= '0;
      sht_dwn   <= '1;
      mute      <= 1'b1;
      flt_sts   <= '0;
    end else begin
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      sht_dwn   <= {NUM_AMP{~pwr_nxt}};
      mute      <= (state_nxt != RUN);
      flt_sts   <= clr_flt ? '0 : (flt_sts | flt);
    end
  end

  assign lockout = (state_q == LOCK);
  assign state   = state_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed vector table plus hand-written corner sequences for amp_pwr_seq.
module tb_amp_pwr_seq;
  import amp_seq_pkg::*;

  localparam int SC = 100;
  localparam int RC = 200;
`ifdef AMP_FLT_DEBOUNCE_EN
  localparam int FL = 3 + 16;
`else
  localparam int FL = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, q_full, clr_flt;
  logic [1:0] Flt_n;
  logic [1:0] sht_dwn, flt_sts;
  logic       mute, lockout;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amp_pwr_seq #(.NUM_AMP(2), .STARTUP_CYC(SC), .RETRY_CYC(RC), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .q_full(q_full), .Flt_n(Flt_n), .clr_flt(clr_flt),
    .sht_dwn(sht_dwn), .mute(mute), .flt_sts(flt_sts), .lockout(lockout), .state(state)
  );

  typedef struct {
    logic       en;
    logic       q;
    logic [1:0] fn;
    logic       clr;
    int         n;
    logic [1:0] sht;
    logic       mute;
    logic [2:0] st;
    logic       lock;
    logic [1:0] sts;
    logic [1:0] rc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic e, input logic q, input logic [1:0] fn, input logic c,
                              input int n, input logic [1:0] sh, input logic mu, input logic [2:0] st,
                              input logic lk, input logic [1:0] ss, input logic [1:0] rc);
    vec_t v;
    v.en = e; v.q = q; v.fn = fn; v.clr = c; v.n = n;
    v.sht = sh; v.mute = mu; v.st = st; v.lock = lk; v.sts = ss; v.rc = rc;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {sht_dwn, mute, state, lockout, flt_sts, dut.retry_cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int k = 0;
    while (state !== s && k < lim) begin
      tick(1);
      k++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state %0d expected %0d within %0d cycles", nm, state, s, lim);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //        en q  Flt_n  clr n         sht    mu st       lk sts    rc
    vq.push_back(mk(0, 0, 2'b11, 0, 2,       2'b11, 1, OFF,     0, 2'b00, 2'd0));
    vq.push_back(mk(1, 0, 2'b11, 0, 1,       2'b11, 1, WAIT_Q,  0, 2'b00, 2'd0));
    vq.push_back(mk(1, 0, 2'b11, 0, 5,       2'b11, 1, WAIT_Q,  0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b00, 1, STARTUP, 0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, SC-1,    2'b00, 1, STARTUP, 0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b00, 0, RUN,     0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b01, 0, FL-1,    2'b00, 0, RUN,     0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b01, 0, 1,       2'b11, 1, RETRY,   0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b01, 0, 2,       2'b11, 1, RETRY,   0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, RC-3,    2'b11, 1, RETRY,   0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b11, 1, WAIT_Q,  0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b00, 1, STARTUP, 0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, SC,      2'b00, 0, RUN,     0, 2'b10, 2'd1));
    vq.push_back(mk(1, 1, 2'b10, 0, FL,      2'b11, 1, RETRY,   0, 2'b11, 2'd2));
    vq.push_back(mk(1, 1, 2'b11, 0, RC-1,    2'b11, 1, RETRY,   0, 2'b11, 2'd2));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b11, 1, WAIT_Q,  0, 2'b11, 2'd2));
    vq.push_back(mk(1, 1, 2'b11, 0, SC+1,    2'b00, 0, RUN,     0, 2'b11, 2'd2));
    vq.push_back(mk(1, 1, 2'b10, 0, FL,      2'b11, 1, LOCK,    1, 2'b11, 2'd3));
    vq.push_back(mk(1, 1, 2'b11, 0, 1000,    2'b11, 1, LOCK,    1, 2'b11, 2'd3));
    vq.push_back(mk(1, 1, 2'b11, 1, 1,       2'b11, 1, OFF,     0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b11, 1, WAIT_Q,  0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b00, 1, STARTUP, 0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b11, 0, SC,      2'b00, 0, RUN,     0, 2'b00, 2'd0));
    vq.push_back(mk(1, 1, 2'b10, 0, FL,      2'b11, 1, RETRY,   0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b10, 0, RC,      2'b11, 1, RETRY,   0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b10, 0, 300,     2'b11, 1, RETRY,   0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, RC/2-1,  2'b11, 1, RETRY,   0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, 1,       2'b11, 1, WAIT_Q,  0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 0, SC+1,    2'b00, 0, RUN,     0, 2'b01, 2'd1));
    vq.push_back(mk(1, 1, 2'b11, 1, 1,       2'b00, 0, RUN,     0, 2'b00, 2'd1));
    vq.push_back(mk(1, 1, 2'b10, 0, FL-1,    2'b00, 0, RUN,     0, 2'b00, 2'd1));
    vq.push_back(mk(0, 1, 2'b10, 0, 1,       2'b11, 1, OFF,     0, 2'b01, 2'd0));
    vq.push_back(mk(0, 1, 2'b11, 0, FL,      2'b11, 1, OFF,     0, 2'b01, 2'd0));

    rst_n = 1'b0; en = 1'b0; q_full = 1'b0; clr_flt = 1'b0; Flt_n = 2'b11;
    tick(2);
    chk("reset_values", 32'(obs()), 32'({2'b11, 1'b1, OFF, 1'b0, 2'b00, 2'd0}));
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; q_full = vq[i].q; Flt_n = vq[i].fn; clr_flt = vq[i].clr;
      tick(vq[i].n);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({vq[i].sht, vq[i].mute, vq[i].st, vq[i].lock, vq[i].sts, vq[i].rc}));
    end

    // Clear coinciding with a live fault in LOCK: clear wins, status reloads one cycle later.
    en = 1'b1; q_full = 1'b1; Flt_n = 2'b11; clr_flt = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_state(RUN, 1000, "reach_run");
      Flt_n = 2'b10;
      tick(FL);
      Flt_n = 2'b11;
    end
    chk("lock_entry", 32'({state, lockout}), 32'({LOCK, 1'b1}));
    Flt_n = 2'b10;
    tick(FL);
    clr_flt = 1'b1;
    tick(1);
    chk("clr_wins", 32'({state, flt_sts, lockout}), 32'({OFF, 2'b00, 1'b0}));
    clr_flt = 1'b0;
    tick(1);
    chk("sts_reload", 32'(flt_sts), 32'(2'b01));

    // Asynchronous reset in the middle of STARTUP.
    en = 1'b0; Flt_n = 2'b11;
    tick(FL + 2);
    en = 1'b1;
    wait_state(STARTUP, 10, "reach_startup");
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(obs()), 32'({2'b11, 1'b1, OFF, 1'b0, 2'b00, 2'd0}));
    tick(2);
    rst_n = 1'b1;

`ifdef AMP_FLT_DEBOUNCE_EN
    wait_state(RUN, 200, "deb_run");
    Flt_n = 2'b10;
    tick(10);
    Flt_n = 2'b11;
    tick(30);
    chk("deb_glitch", 32'({state, flt_sts}), 32'({RUN, 2'b00}));
    Flt_n = 2'b10;
    tick(FL - 1);
    chk("deb_before", 32'(state), 32'(RUN));
    tick(1);
    chk("deb_retry", 32'(state), 32'(RETRY));
    tick(1);
    Flt_n = 2'b11;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amp_pwr_seq.md
# amp_pwr_seq

Parametrised power-sequencing and fault manager for class-D amplifier channels, replacing the fixed single-amp shutdown timer in the Equalizer top level. It holds every amp in shutdown until the low-frequency queues report full, then releases shutdown, waits a settle period before unmuting, and reacts to filtered amp faults. Fault handling uses timed auto-retry up to a limit, then a latched lockout. It sits beside `spkr_drv` and drives `sht_dwn` and a mute qualifier for the PDM outputs.

## Interface
- NUM_AMP, 2, number of amplifier channels (fault inputs / shutdown outputs)
- STARTUP_CYC, 250000, clocks from shutdown release to unmute (5 ms @ 50 MHz)
- RETRY_CYC, 2500000, clocks held in shutdown after a fault before re-attempting
- MAX_RETRY, 3, number of faults tolerated before lockout (≥1)
- DEB_CYC, 16, clocks a synchronised fault must be stable before acceptance (debounce build only)
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset (already synchronised by `rst_synch`)
- en  in  1  level; request amplifiers on
- q_full  in  1  level; low-frequency queues full, audio valid
- Flt_n  in  NUM_AMP  asynchronous active-low amp faults, one per channel
- clr_flt  in  1  single-cycle pulse; clear lockout and sticky status
- sht_dwn  out  NUM_AMP  active-high shutdown, one per amp, registered
- mute  out  1  active-high; `spkr_drv` forces 50 % duty when set, registered
- flt_sts  out  NUM_AMP  sticky per-channel fault record
- lockout  out  1  high while in LOCK
- state  out  3  current `amp_state_t` encoding, for debug/LED

## Operation
- **Fault filter:** each `Flt_n` bit is 2-flop synchronised. It is then inverted to give `flt[i]`. `flt_any` is the OR of all `flt[i]`.
- **OFF:** all `sht_dwn` = 1, `mute` = 1. `en` = 1 → WAIT_Q.
- **WAIT_Q:** shutdown and mute held. `q_full` = 1 → STARTUP, timer cleared.
- **STARTUP:** all `sht_dwn` = 0, `mute` = 1. When the timer reaches STARTUP_CYC−1 → RUN.
- **RUN:** `sht_dwn` = 0, `mute` = 0.
- **Fault in STARTUP or RUN:** the next state is RETRY and `retry_cnt` increments. If the incremented count equals MAX_RETRY, the next state is LOCK instead.
- **RETRY:** all `sht_dwn` = 1, `mute` = 1, timer counts to RETRY_CYC−1.
  - On expiry with `flt_any` = 0 → WAIT_Q.
  - On expiry with `flt_any` = 1 → timer restarts and `retry_cnt` is not incremented.
- **LOCK:** everything shut down, `lockout` = 1. Only `clr_flt` exits, to OFF. The exit clears `retry_cnt` and `flt_sts`.
- **flt_sts:** `flt_sts[i]` is set whenever `flt[i]` = 1, in any state. It is cleared only by `clr_flt`, or by reset.
- **en = 0:** from any state except LOCK, the next state is OFF and `retry_cnt` is cleared. `flt_sts` is kept.
- **Simultaneous events:**
  - `en` falling together with a fault in RUN → OFF. `flt_sts` still records the fault.
  - `clr_flt` together with a fault in LOCK → OFF. The clear wins, and `flt_sts` reloads from the fault bits in the next cycle.
  - `clr_flt` outside LOCK clears `flt_sts` only.
- **Counter widths:**
  - Timer width is `$clog2` of max(STARTUP_CYC, RETRY_CYC). It saturates and never wraps.
  - `retry_cnt` width is `$clog2(MAX_RETRY+1)`.

## Timing
- **Reset values:** `sht_dwn` = all 1, `mute` = 1, `flt_sts` = 0, `lockout` = 0, `state` = OFF, timer = 0, `retry_cnt` = 0.
- **Reset mid-operation:** returns to these values immediately (asynchronous).
- **Fault latency:** `Flt_n` falling → `sht_dwn` high 3 clocks later (2 sync + 1 registered output) in the non-debounce build.
- **Startup latency:** `q_full` rising in WAIT_Q → `sht_dwn` low after 1 clock. `mute` falls exactly STARTUP_CYC clocks after that.
- **Retry latency:** RETRY entered → WAIT_Q entered RETRY_CYC clocks later (fault cleared case).

## Configuration
- **`AMP_FLT_DEBOUNCE_EN` defined:** each synchronised fault must be stable for DEB_CYC consecutive clocks before `flt[i]` changes, in both directions. Fault latency becomes 3 + DEB_CYC clocks. Glitches shorter than DEB_CYC are ignored and do not set `flt_sts`.
- **Undefined:** no debounce; `flt[i]` is the 2-flop synchronised bit and DEB_CYC is unused.

## Structure
- Package `amp_seq_pkg` holds:
  - `typedef enum logic [2:0] amp_state_t` with OFF, WAIT_Q, STARTUP, RUN, RETRY, LOCK;
  - the default timing localparams.
- Sub-module `flt_filt`: one instance per channel via generate. It contains the synchroniser plus the optional debounce counter.

## Test plan
- **Startup:** `en` = 1, `q_full` = 1 at cycle 10 (STARTUP_CYC = 100) → `sht_dwn` = 2'b00 at cycle 11, `mute` falls at cycle 111, `state` = RUN.
- **Single fault:** in RUN, pulse `Flt_n[1]` low for 5 clocks (RETRY_CYC = 200) → `sht_dwn` = 2'b11 3 clocks after the pulse, `flt_sts` = 2'b10. After 200 clocks the block returns to WAIT_Q, then STARTUP.
- **Lockout:** MAX_RETRY = 3, with a fault in each RUN → the third fault enters LOCK, `lockout` = 1. The block stays in LOCK 1000 clocks with `en` = 1. A `clr_flt` pulse → OFF, `flt_sts` = 0.
- **Persistent fault:** `Flt_n[0]` held low through RETRY expiry → timer restarts and `retry_cnt` stays unchanged. The block stays in RETRY until the fault is released.
- **Simultaneous events:**
  - `en` drops in the same cycle as a fault in RUN → OFF, `retry_cnt` = 0, `flt_sts` = 2'b01.
  - `rst_n` asserted mid-STARTUP → all outputs at reset values the same cycle.
- **Debounce build (`AMP_FLT_DEBOUNCE_EN`, DEB_CYC = 16):**
  - 10-clock glitch → no state change, `flt_sts` = 0.
  - 20-clock fault → RETRY entered 19 clocks after `Flt_n` falls.
